// File: rtl/grf_write_arbiter_if.sv
// Bundle of the GRF write-arbiter traffic: W-stage writeback, debug writer,
// clear-sweep control, stall request and the shared GRF write port.
interface grf_write_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;

  logic        dbg_valid;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        dbg_ready;

  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;

  logic        stall_req;

  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;

  // Requester side: pipeline, debug path and clear control.
  modport master (
    output wb_we, wb_addr, wb_data, wb_pc,
    output dbg_valid, dbg_addr, dbg_data,
    input  dbg_ready,
    output clr_start,
    input  clr_busy, clr_done, stall_req,
    input  grf_we, grf_a3, grf_wd, grf_pc
  );

  // Arbiter side.
  modport slave (
    input  wb_we, wb_addr, wb_data, wb_pc,
    input  dbg_valid, dbg_addr, dbg_data,
    output dbg_ready,
    input  clr_start,
    output clr_busy, clr_done, stall_req,
    output grf_we, grf_a3, grf_wd, grf_pc
  );
endinterface

// File: rtl/grf_write_arbiter.sv
// Shares the GRF write port among W-stage writeback, debug writes and a $1..$31 clear sweep.
// Optional debug-starvation stall enabled by defining GRF_ARB_STARVE_EN.
module grf_write_arbiter #(
  parameter int          STARVE_LIMIT = 8,
  parameter logic [31:0] DBG_PC       = 32'hFFFF_FFFC
) (
  input logic                  clk,
  input logic                  reset,
  grf_write_arbiter_if.slave   bus
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("grf_write_arbiter: STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  clr_cnt, clr_cnt_nxt;
  logic        stall_q, stall_nxt;
  logic        starve_hit;

  logic        wb_active;
  logic        dbg_ready_int;
  logic        dbg_fire;
  logic        clr_write;
  logic        clr_last;

  assign wb_active     = bus.wb_we && (bus.wb_addr != 5'd0);
  assign dbg_ready_int = !reset && (state == IDLE) && !wb_active;
  assign dbg_fire      = bus.dbg_valid && dbg_ready_int;
  // The sweep only advances in cycles the W stage leaves the port free.
  assign clr_write     = !reset && (state == CLEAR) && !wb_active;
  assign clr_last      = clr_write && (clr_cnt == 5'd31);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state   <= IDLE;
      clr_cnt <= 5'd1;
      stall_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      stall_q <= stall_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    unique case (state)
      IDLE: begin
        if (bus.clr_start) state_nxt = CLEAR;
      end
      CLEAR: begin
        if (clr_last) begin
          state_nxt   = IDLE;
          clr_cnt_nxt = 5'd1;
        end else if (clr_write) begin
          clr_cnt_nxt = clr_cnt + 5'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef GRF_ARB_STARVE_EN
  logic [3:0] starve_cnt, starve_cnt_nxt;

  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!bus.dbg_valid || dbg_fire) begin
      starve_cnt_nxt = 4'd0;
    end else if ((state == IDLE) && !dbg_ready_int && (starve_cnt != 4'hF)) begin
      starve_cnt_nxt = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) starve_cnt <= 4'd0;
    else       starve_cnt <= starve_cnt_nxt;
  end

  // Compare the post-increment count so the stall lands on the edge that
  // ends the limit-th waiting cycle.
  assign starve_hit = (starve_cnt_nxt >= 4'(STARVE_LIMIT));
`else
  assign starve_hit = 1'b0;
`endif

  assign stall_nxt = (state_nxt == CLEAR) || starve_hit;

  // Output logic: W stage first, then the sweep, then the debug writer.
  always_comb begin
    bus.grf_we    = 1'b0;
    bus.grf_a3    = 5'd0;
    bus.grf_wd    = 32'd0;
    bus.grf_pc    = 32'd0;
    bus.dbg_ready = dbg_ready_int;
    bus.clr_busy  = !reset && (state == CLEAR);
    bus.clr_done  = clr_last;
    bus.stall_req = stall_q;
    if (!reset) begin
      if (wb_active) begin
        bus.grf_we = 1'b1;
        bus.grf_a3 = bus.wb_addr;
        bus.grf_wd = bus.wb_data;
        bus.grf_pc = bus.wb_pc;
      end else if (clr_write) begin
        bus.grf_we = 1'b1;
        bus.grf_a3 = clr_cnt;
        bus.grf_pc = DBG_PC;
      end else if (dbg_fire) begin
        // A debug write to $0 still completes its handshake.
        bus.grf_we = (bus.dbg_addr != 5'd0);
        bus.grf_a3 = bus.dbg_addr;
        bus.grf_wd = bus.dbg_data;
        bus.grf_pc = DBG_PC;
      end
    end
  end

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Directed bench for grf_write_arbiter: arbitration priority, debug handshake,
// clear sweep (clean, contended, aborted by reset) and debug starvation.
module tb_grf_write_arbiter;
  localparam logic [31:0] DBG_PC = 32'hFFFF_FFFC;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   done_cnt;
  int   exp_reg;
  bit   wb_cyc;

  grf_write_arbiter_if bus ();

  grf_write_arbiter #(
    .STARVE_LIMIT (8),
    .DBG_PC       (DBG_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are checked 2ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    bus.wb_we     = 1'b0;
    bus.wb_addr   = 5'd0;
    bus.wb_data   = 32'd0;
    bus.wb_pc     = 32'd0;
    bus.dbg_valid = 1'b0;
    bus.dbg_addr  = 5'd0;
    bus.dbg_data  = 32'd0;
    bus.clr_start = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle_inputs();
    // Traffic during reset must not reach the port.
    bus.wb_we     = 1'b1;
    bus.wb_addr   = 5'd3;
    bus.dbg_valid = 1'b1;
    bus.dbg_addr  = 5'd6;
    tick();
    tick();
    settle();
    check("rst_grf_we",    bus.grf_we,    0);
    check("rst_dbg_ready", bus.dbg_ready, 0);
    check("rst_stall",     bus.stall_req, 0);
    check("rst_clr_busy",  bus.clr_busy,  0);
    check("rst_clr_done",  bus.clr_done,  0);

    tick();
    reset = 1'b0;
    idle_inputs();
    settle();
    check("idle_we",    bus.grf_we,    0);
    check("idle_a3",    bus.grf_a3,    0);
    check("idle_wd",    bus.grf_wd,    0);
    check("idle_pc",    bus.grf_pc,    0);
    check("idle_ready", bus.dbg_ready, 1);

    // Uncontended debug write.
    tick();
    bus.dbg_valid = 1'b1;
    bus.dbg_addr  = 5'd5;
    bus.dbg_data  = 32'hDEADBEEF;
    settle();
    check("dbg_ready", bus.dbg_ready, 1);
    check("dbg_we",    bus.grf_we,    1);
    check("dbg_a3",    bus.grf_a3,    5);
    check("dbg_wd",    bus.grf_wd,    32'hDEADBEEF);
    check("dbg_pc",    bus.grf_pc,    DBG_PC);

    // Three W-stage writes hold off a pending debug write.
    for (int c = 1; c <= 3; c++) begin
      tick();
      bus.wb_we     = 1'b1;
      bus.wb_addr   = 5'd3;
      bus.wb_data   = 32'h1111_0000 + 32'(c);
      bus.wb_pc     = 32'h0000_3000 + 32'(4 * c);
      bus.dbg_valid = 1'b1;
      bus.dbg_addr  = 5'd9;
      bus.dbg_data  = 32'h0000_CAFE;
      settle();
      check("wb_pri_ready", bus.dbg_ready, 0);
      check("wb_pri_a3",    bus.grf_a3,    3);
      check("wb_pri_wd",    bus.grf_wd,    32'h1111_0000 + 32'(c));
      check("wb_pri_pc",    bus.grf_pc,    32'h0000_3000 + 32'(4 * c));
    end
    tick();
    bus.wb_we = 1'b0;
    settle();
    check("dbg_late_ready", bus.dbg_ready, 1);
    check("dbg_late_a3",    bus.grf_a3,    9);
    check("dbg_late_wd",    bus.grf_wd,    32'h0000_CAFE);
    check("dbg_late_pc",    bus.grf_pc,    DBG_PC);

    // A writeback to $0 is not a real write; debug wins the port.
    tick();
    bus.wb_we     = 1'b1;
    bus.wb_addr   = 5'd0;
    bus.wb_data   = 32'h5555_5555;
    bus.dbg_addr  = 5'd7;
    bus.dbg_data  = 32'h0000_0077;
    settle();
    check("wb0_ready", bus.dbg_ready, 1);
    check("wb0_we",    bus.grf_we,    1);
    check("wb0_a3",    bus.grf_a3,    7);
    check("wb0_wd",    bus.grf_wd,    32'h0000_0077);

    // Debug write to $0: handshake without a write.
    tick();
    bus.wb_we    = 1'b0;
    bus.dbg_addr = 5'd0;
    settle();
    check("dbg0_ready", bus.dbg_ready, 1);
    check("dbg0_we",    bus.grf_we,    0);

    // Clear sweep with a same-cycle debug request served in cycle 0.
    tick();
    idle_inputs();
    bus.clr_start = 1'b1;
    bus.dbg_valid = 1'b1;
    bus.dbg_addr  = 5'd4;
    bus.dbg_data  = 32'h0000_0044;
    settle();
    check("c0_dbg_ready", bus.dbg_ready, 1);
    check("c0_a3",        bus.grf_a3,    4);
    check("c0_busy",      bus.clr_busy,  0);
    done_cnt = 0;
    for (int c = 1; c <= 31; c++) begin
      tick();
      idle_inputs();
      if (c == 5) bus.clr_start = 1'b1;
      if (c >= 10 && c <= 12) bus.dbg_valid = 1'b1;
      settle();
      if (bus.clr_done === 1'b1) done_cnt++;
      check("clr_busy",  bus.clr_busy,  1);
      check("clr_ready", bus.dbg_ready, 0);
      check("clr_stall", bus.stall_req, 1);
      check("clr_we",    bus.grf_we,    1);
      check("clr_a3",    bus.grf_a3,    32'(c));
      check("clr_wd",    bus.grf_wd,    0);
      check("clr_pc",    bus.grf_pc,    DBG_PC);
      check("clr_done",  bus.clr_done,  (c == 31) ? 1 : 0);
    end
    check("clr_done_count", 32'(done_cnt), 1);
    tick();
    settle();
    check("post_clr_busy",  bus.clr_busy,  0);
    check("post_clr_stall", bus.stall_req, 0);
    check("post_clr_ready", bus.dbg_ready, 1);
    check("post_clr_we",    bus.grf_we,    0);

    // Sweep with two writeback cycles at cycles 5 and 6: ends at cycle 33.
    tick();
    bus.clr_start = 1'b1;
    settle();
    exp_reg = 1;
    for (int c = 1; c <= 33; c++) begin
      tick();
      idle_inputs();
      wb_cyc = (c == 5 || c == 6);
      if (wb_cyc) begin
        bus.wb_we   = 1'b1;
        bus.wb_addr = 5'd12;
        bus.wb_data = 32'(c);
      end
      settle();
      check("cw_busy", bus.clr_busy, 1);
      if (wb_cyc) begin
        check("cw_wb_a3", bus.grf_a3, 12);
        check("cw_wb_wd", bus.grf_wd, 32'(c));
      end else begin
        check("cw_a3", bus.grf_a3, 32'(exp_reg));
        check("cw_wd", bus.grf_wd, 0);
      end
      check("cw_done", bus.clr_done, (!wb_cyc && exp_reg == 31) ? 1 : 0);
      if (!wb_cyc) exp_reg++;
    end
    tick();
    settle();
    check("cw_end_busy", bus.clr_busy, 0);

    // Reset at cycle 10 of a sweep aborts it without clr_done.
    tick();
    bus.clr_start = 1'b1;
    settle();
    for (int c = 1; c <= 9; c++) begin
      tick();
      bus.clr_start = 1'b0;
    end
    tick();
    reset         = 1'b1;
    bus.dbg_valid = 1'b1;
    bus.dbg_addr  = 5'd2;
    settle();
    check("abort_done",  bus.clr_done,  0);
    check("abort_we",    bus.grf_we,    0);
    check("abort_ready", bus.dbg_ready, 0);
    tick();
    reset = 1'b0;
    idle_inputs();
    settle();
    check("abort_busy",  bus.clr_busy,  0);
    check("abort_stall", bus.stall_req, 0);
    check("abort_idle",  bus.dbg_ready, 1);
    tick();
    bus.clr_start = 1'b1;
    settle();
    tick();
    bus.clr_start = 1'b0;
    settle();
    check("restart_a3", bus.grf_a3, 1);
    // Reset clears the restarted sweep before the starvation section.
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    settle();
    check("restart_abort_busy", bus.clr_busy, 0);

    // Debug request stuck behind continuous writebacks.
    for (int w = 1; w <= 12; w++) begin
      tick();
      bus.wb_we     = 1'b1;
      bus.wb_addr   = 5'd8;
      bus.wb_data   = 32'(w);
      bus.dbg_valid = 1'b1;
      bus.dbg_addr  = 5'd10;
      bus.dbg_data  = 32'h0000_00AA;
      settle();
      check("starve_ready", bus.dbg_ready, 0);
`ifdef GRF_ARB_STARVE_EN
      check("starve_stall", bus.stall_req, (w >= 9) ? 1 : 0);
`else
      check("nostarve_stall", bus.stall_req, 0);
`endif
    end
    tick();
    bus.wb_we = 1'b0;
    settle();
    check("starve_grant_ready", bus.dbg_ready, 1);
    check("starve_grant_a3",    bus.grf_a3,    10);
`ifdef GRF_ARB_STARVE_EN
    check("starve_grant_stall", bus.stall_req, 1);
`else
    check("nostarve_grant_stall", bus.stall_req, 0);
`endif
    tick();
    idle_inputs();
    settle();
    check("starve_release_stall", bus.stall_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
